joint_pwm_ctrl: RTL
===================

# joint_pwm_ctrl

Per-joint sequencing controller that sits between the host command register file and a PWM/DIR joint output stage. It accepts signed duty commands and drives the stage's signed duty input. It slew-limits that duty and forces a ramp-to-zero plus dead time on every direction reversal. It also zeroes the output on disable or on a command-watchdog timeout, so the power stage never sees an abrupt reversal or a stale command.

## Interface

Parameters:
- PWM_PERIOD, 100000: duty magnitude ceiling; must equal the PWM stage period count.
- TICK_DIV, 1000: clocks per slew-update tick.
- SLEW_STEP, 100: maximum duty change per tick.
- DEAD_CYCLES, 5000: clocks held at zero duty before a reversed direction is applied.
- WDOG_CYCLES, 5000000: clocks without cmdStrobe before a fault is raised.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- jointEnable  in  1  joint enable from the host.
- cmdDuty  in  32 signed  requested duty; sign selects direction.
- cmdStrobe  in  1  one-cycle pulse: cmdDuty is valid and refreshes the watchdog.
- dutyOut  out  32 signed  duty to the PWM stage.
- outEnable  out  1  enable to the PWM stage.
- fault  out  1  watchdog fault is latched.
- state  out  3  current state: IDLE=0, RUN=1, RAMP_DOWN=2, DEADTIME=3, FAULT=4.

## Operation

- Target register:
  - Loaded on cmdStrobe in any state, including IDLE and FAULT.
  - Value is cmdDuty with its magnitude clamped to PWM_PERIOD; sign is kept.
  - Magnitude is computed in 33 bits, so -2^31 clamps to -PWM_PERIOD.
- Tick divider:
  - Free-running 0..TICK_DIV-1; tick asserts on the count TICK_DIV-1.
  - Cleared only by reset.
- Step rule ("move toward X"):
  - If |X - dutyOut| <= SLEW_STEP, dutyOut = X.
  - Otherwise dutyOut changes by SLEW_STEP in the direction of X.
- Sign conflict: target and dutyOut are both nonzero with opposite signs. A zero value conflicts with nothing.
- IDLE:
  - dutyOut=0, outEnable=0, watchdog counter held at 0.
  - jointEnable=1 -> RUN.
- RUN:
  - outEnable=1.
  - On tick with a sign conflict -> RAMP_DOWN, applying the first step toward 0 on that same tick.
  - On tick without a conflict, move toward target.
- RAMP_DOWN:
  - On each tick, move toward 0.
  - When dutyOut reaches 0 -> DEADTIME, load the dead counter with DEAD_CYCLES.
- DEADTIME:
  - dutyOut=0, outEnable stays 1.
  - Dead counter decrements every clock; on reaching 0 -> RUN.
  - The new sign applies from the next tick after that.
- FAULT:
  - dutyOut=0, outEnable=0, fault=1.
  - Exit only when jointEnable=0 -> IDLE; fault clears on that transition.
- Disable: jointEnable=0 in RUN, RAMP_DOWN or DEADTIME -> IDLE with dutyOut=0 immediately, no ramp. This has priority over all other transitions.
- Watchdog:
  - Counts in RUN, RAMP_DOWN and DEADTIME; cleared by cmdStrobe.
  - Reaching WDOG_CYCLES -> FAULT.
  - cmdStrobe in the same cycle as expiry wins: counter cleared, no fault.
- Transition priority: reset > disable > watchdog > tick/dead-time.

## Timing

- All outputs registered. A state change and its dutyOut/outEnable/fault values appear together on the clock edge after the causing condition.
- Reset values: dutyOut=0, outEnable=0, fault=0, state=IDLE, target=0, all counters 0.
- cmdStrobe to target update: 1 clock. Target to first dutyOut change: up to TICK_DIV clocks.
- Full-scale ramp 0 -> PWM_PERIOD takes ceil(PWM_PERIOD/SLEW_STEP) ticks.
- Reversal latency:
  - Ramp-down ticks to reach 0, plus DEAD_CYCLES clocks, plus one tick before the first opposite-sign value.
  - dutyOut is never nonzero with opposite sign across fewer than DEAD_CYCLES+1 clocks at zero.
- Reset mid-operation: the next edge gives IDLE with all outputs at reset values.

## Test plan

Bench parameters: PWM_PERIOD=100, TICK_DIV=4, SLEW_STEP=10, DEAD_CYCLES=8, WDOG_CYCLES=200.

- Ramp-up: enable, strobe +35 -> state=RUN, dutyOut 10, 20, 30, 35 on successive ticks (4 clocks apart), then holds 35.
- Clamp: strobe +500 -> target 100; strobe 0x80000000 -> target -100. dutyOut never exceeds magnitude 100.
- Reversal:
  - Sequence: at dutyOut=+25, strobe -20.
  - Expected: dutyOut 15, 5, 0; state=DEADTIME for 8 clocks at 0; then RUN; -10, -20 on following ticks.
- Disable mid-ramp: jointEnable=0 while dutyOut=+60 -> next clock dutyOut=0, outEnable=0, state=IDLE.
- Watchdog:
  - No strobe for 200 clocks in RUN -> state=FAULT, fault=1, dutyOut=0.
  - A strobe in that expiry cycle instead -> no fault.
  - From FAULT, jointEnable=0 -> IDLE, fault=0.
- Reset during DEADTIME -> next clock all outputs at reset values, state=IDLE.

Source files
------------

// File: rtl/joint_pwm_ctrl.sv
// joint_pwm_ctrl: per-joint sequencer between the host command registers and a
// PWM/DIR output stage. It slew-limits the signed duty and forces ramp-to-zero
// plus dead time on every direction reversal. It also zeroes the output on
// disable or when the host stops refreshing the command (watchdog fault).
//
// Command handshake: cmdStrobe is a one-cycle valid pulse with no ready/back-
// pressure. cmdDuty is sampled on every clock where cmdStrobe=1, in any state.
// That sample loads the target and restarts the watchdog.
module joint_pwm_ctrl #(
    parameter int PWM_PERIOD  = 100000,
    parameter int TICK_DIV    = 1000,
    parameter int SLEW_STEP   = 100,
    parameter int DEAD_CYCLES = 5000,
    parameter int WDOG_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jointEnable,
    input  logic signed [31:0] cmdDuty,
    input  logic               cmdStrobe,
    output logic signed [31:0] dutyOut,
    output logic               outEnable,
    output logic               fault,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_RAMP_DOWN = 3'd2,
        ST_DEADTIME  = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    localparam logic signed [33:0] PMAX_W  = 34'(PWM_PERIOD);
    localparam logic signed [31:0] PMAX_D  = 32'(PWM_PERIOD);
    localparam logic signed [33:0] STEP_W  = 34'(SLEW_STEP);
    localparam logic signed [31:0] STEP_D  = 32'(SLEW_STEP);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEAD_W-1:0]  DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    state_t               state_q;
    logic signed [31:0]   target_q;
    logic signed [31:0]   duty_q;
    logic                 oe_q;
    logic                 fault_q;
    logic [TICK_W-1:0]    tick_cnt;
    logic [DEAD_W-1:0]    dead_cnt;
    logic [WDOG_W-1:0]    wdog_cnt;

    logic                 tick;
    logic                 dead_done;
    logic                 wdog_expire;
    logic                 sign_conflict;
    logic signed [31:0]   cmd_clamped;
    logic signed [31:0]   step_to_target;
    logic signed [31:0]   step_to_zero;

    // One slew step from cur toward dst; snaps onto dst when within one step.
    function automatic logic signed [31:0] move_toward(input logic signed [31:0] cur,
                                                       input logic signed [31:0] dst);
        logic signed [33:0] diff;
        diff = $signed({{2{dst[31]}}, dst}) - $signed({{2{cur[31]}}, cur});
        if (diff > STEP_W) begin
            move_toward = cur + STEP_D;
        end else if (diff < -STEP_W) begin
            move_toward = cur - STEP_D;
        end else begin
            move_toward = dst;
        end
    endfunction

    // Clamp magnitude to the PWM period while keeping the sign. The compare is
    // done on a 34-bit sign extension so the most negative input cannot wrap.
    function automatic logic signed [31:0] clamp_duty(input logic signed [31:0] raw);
        logic signed [33:0] ext;
        ext = $signed({{2{raw[31]}}, raw});
        if (ext > PMAX_W) begin
            clamp_duty = PMAX_D;
        end else if (ext < -PMAX_W) begin
            clamp_duty = -PMAX_D;
        end else begin
            clamp_duty = raw;
        end
    endfunction

    // Decode ticks, counter terminal values, reversal detection and next step values.
    always_comb begin
        tick           = (tick_cnt == TICK_LAST);
        dead_done      = (dead_cnt <= DEAD_W'(1));
        wdog_expire    = (wdog_cnt == WDOG_LAST);
        cmd_clamped    = clamp_duty(cmdDuty);
        step_to_target = move_toward(duty_q, target_q);
        step_to_zero   = move_toward(duty_q, 32'sd0);
        // A zero on either side is never a reversal.
        sign_conflict  = (target_q[31] && !duty_q[31] && (duty_q != '0)) ||
                         (duty_q[31] && !target_q[31] && (target_q != '0));
    end

    // Sequencer: state, registered outputs, target, tick, dead-time and watchdog counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            duty_q   <= '0;
            oe_q     <= 1'b0;
            fault_q  <= 1'b0;
            tick_cnt <= '0;
            dead_cnt <= '0;
            wdog_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            if (cmdStrobe) begin
                target_q <= cmd_clamped;
            end

            case (state_q)
                ST_IDLE: begin
                    duty_q   <= '0;
                    fault_q  <= 1'b0;
                    wdog_cnt <= '0;
                    dead_cnt <= '0;
                    if (jointEnable) begin
                        state_q <= ST_RUN;
                        oe_q    <= 1'b1;
                    end else begin
                        oe_q    <= 1'b0;
                    end
                end

                ST_FAULT: begin
                    duty_q   <= '0;
                    oe_q     <= 1'b0;
                    wdog_cnt <= '0;
                    dead_cnt <= '0;
                    if (!jointEnable) begin
                        state_q <= ST_IDLE;
                        fault_q <= 1'b0;
                    end else begin
                        fault_q <= 1'b1;
                    end
                end

                ST_RUN, ST_RAMP_DOWN, ST_DEADTIME: begin
                    if (!jointEnable) begin
                        // Disable drops the output at once, no ramp.
                        state_q  <= ST_IDLE;
                        duty_q   <= '0;
                        oe_q     <= 1'b0;
                        wdog_cnt <= '0;
                        dead_cnt <= '0;
                    end else if (wdog_expire && !cmdStrobe) begin
                        state_q  <= ST_FAULT;
                        duty_q   <= '0;
                        oe_q     <= 1'b0;
                        fault_q  <= 1'b1;
                        wdog_cnt <= '0;
                        dead_cnt <= '0;
                    end else begin
                        wdog_cnt <= cmdStrobe ? '0 : wdog_cnt + 1'b1;
                        oe_q     <= 1'b1;
                        case (state_q)
                            ST_RUN: begin
                                if (tick) begin
                                    if (sign_conflict) begin
                                        // First step toward zero happens on the detecting tick.
                                        duty_q <= step_to_zero;
                                        if (step_to_zero == '0) begin
                                            state_q  <= ST_DEADTIME;
                                            dead_cnt <= DEAD_LOAD;
                                        end else begin
                                            state_q  <= ST_RAMP_DOWN;
                                        end
                                    end else begin
                                        duty_q <= step_to_target;
                                    end
                                end
                            end
                            ST_RAMP_DOWN: begin
                                if (tick) begin
                                    duty_q <= step_to_zero;
                                    if (step_to_zero == '0) begin
                                        state_q  <= ST_DEADTIME;
                                        dead_cnt <= DEAD_LOAD;
                                    end
                                end
                            end
                            ST_DEADTIME: begin
                                // The reversed sign is only applied by a later RUN tick.
                                duty_q <= '0;
                                if (dead_done) begin
                                    state_q  <= ST_RUN;
                                    dead_cnt <= '0;
                                end else begin
                                    dead_cnt <= dead_cnt - 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    duty_q   <= '0;
                    oe_q     <= 1'b0;
                    fault_q  <= 1'b0;
                    wdog_cnt <= '0;
                    dead_cnt <= '0;
                end
            endcase
        end
    end

    assign dutyOut   = duty_q;
    assign outEnable = oe_q;
    assign fault     = fault_q;
    assign state     = state_q;

    // The stage never sees a duty while disabled, nor one beyond its period.
    a_zero_when_disabled: assert property (@(posedge clk) disable iff (reset)
        !outEnable |-> (dutyOut == '0));
    a_duty_in_range: assert property (@(posedge clk) disable iff (reset)
        (dutyOut <= PMAX_D) && (dutyOut >= -PMAX_D));

endmodule
